regfile_write_arbiter: RTL and testbench

//  Upstream write-side stage of the 128x64 register file. Collects writeback requests from
//  NUM_IN producer lanes (valid/ready). Buffers each lane in a small FIFO and allocates up to
//  NUM_PORTS requests per cycle onto the register file write ports, round-robin.

---
 rtl/regfile_write_arbiter.sv | 175 +++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Write-side arbiter for the register file: per-lane FIFOs feed up to NUM_PORTS
// registered write ports each cycle, round-robin, with no duplicate address per cycle.
module regfile_write_arbiter #(
    parameter int NUM_IN     = 12,
    parameter int NUM_PORTS  = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 64
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [NUM_IN-1:0]                      io_in_valid,
    output logic [NUM_IN-1:0]                      io_in_ready,
    input  logic [NUM_IN*ADDR_W-1:0]               io_in_address,
    input  logic [NUM_IN*DATA_W-1:0]               io_in_value,
    input  logic [NUM_IN*(DATA_W/8)-1:0]           io_in_byteMask,
    output logic [NUM_PORTS-1:0]                   io_wr_write,
    output logic [NUM_PORTS*ADDR_W-1:0]            io_wr_address,
    output logic [NUM_PORTS*DATA_W-1:0]            io_wr_value,
    output logic [NUM_PORTS*(DATA_W/8)-1:0]        io_wr_byteMask,
    output logic [$clog2(NUM_IN*FIFO_DEPTH+1)-1:0] io_pending,
    output logic                                   io_idle
);

    localparam int MASK_W = DATA_W / 8;
    localparam int PEND_W = $clog2(NUM_IN * FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int LANE_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int IDX_W  = LANE_W + 1;
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [ADDR_W-1:0] fifo_addr  [NUM_IN][FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_value [NUM_IN][FIFO_DEPTH];
    logic [MASK_W-1:0] fifo_mask  [NUM_IN][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr     [NUM_IN];
    logic [PTR_W-1:0]  wr_ptr     [NUM_IN];
    logic [CNT_W-1:0]  count      [NUM_IN];

    logic [ADDR_W-1:0] head_addr  [NUM_IN];
    logic [DATA_W-1:0] head_value [NUM_IN];
    logic [MASK_W-1:0] head_mask  [NUM_IN];
    logic [NUM_IN-1:0] non_empty;
    logic [NUM_IN-1:0] enq;
    logic [NUM_IN-1:0] grant;
    logic [PORT_W-1:0] port_of    [NUM_IN];

    logic [LANE_W-1:0] rr_ptr;
    logic [LANE_W-1:0] rr_next;

    logic [NUM_PORTS-1:0]        wr_write_n;
    logic [NUM_PORTS*ADDR_W-1:0] wr_address_n;
    logic [NUM_PORTS*DATA_W-1:0] wr_value_n;
    logic [NUM_PORTS*MASK_W-1:0] wr_mask_n;

    always_comb begin
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            head_addr[i]   = fifo_addr[i][rd_ptr[i]];
            head_value[i]  = fifo_value[i][rd_ptr[i]];
            head_mask[i]   = fifo_mask[i][rd_ptr[i]];
            non_empty[i]   = (count[i] != '0);
            io_in_ready[i] = !reset && (count[i] != CNT_W'(FIFO_DEPTH));
            enq[i]         = io_in_valid[i] && io_in_ready[i];
        end
    end

    // Scan from rr_ptr; the first head passed over (out of ports or address clash)
    // becomes the next starting point so it cannot starve.
    always_comb begin : grant_scan
        logic [IDX_W-1:0]  idx;
        logic [LANE_W-1:0] lane;
        logic [NUM_IN-1:0] g;
        logic              conflict;
        logic              skipped;
        int unsigned       used;
        g        = '0;
        idx      = '0;
        lane     = '0;
        conflict = 1'b0;
        skipped  = 1'b0;
        used     = 0;
        rr_next  = rr_ptr;
        for (int unsigned i = 0; i < NUM_IN; i++) port_of[i] = '0;
        for (int unsigned j = 0; j < NUM_IN; j++) begin
            idx = {1'b0, rr_ptr} + IDX_W'(j);
            if (idx >= IDX_W'(NUM_IN)) idx = idx - IDX_W'(NUM_IN);
            lane = idx[LANE_W-1:0];
            if (non_empty[lane]) begin
                conflict = 1'b0;
                for (int unsigned i = 0; i < NUM_IN; i++) begin
                    if (g[i] && (head_addr[i] == head_addr[lane])) conflict = 1'b1;
                end
                if ((used < NUM_PORTS) && !conflict) begin
                    g[lane]       = 1'b1;
                    port_of[lane] = PORT_W'(used);
                    used          = used + 1;
                end else if (!skipped) begin
                    skipped = 1'b1;
                    rr_next = lane;
                end
            end
        end
        if (!skipped && (used != 0)) begin
            rr_next = (rr_ptr == LANE_W'(NUM_IN - 1)) ? '0 : rr_ptr + LANE_W'(1);
        end
        grant = g;
    end

    always_comb begin
        wr_write_n   = '0;
        wr_address_n = '0;
        wr_value_n   = '0;
        wr_mask_n    = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (grant[i] && (port_of[i] == PORT_W'(k))) begin
                    wr_write_n[k]                     = 1'b1;
                    wr_address_n[k*ADDR_W +: ADDR_W] = head_addr[i];
                    wr_value_n[k*DATA_W +: DATA_W]   = head_value[i];
                    wr_mask_n[k*MASK_W +: MASK_W]    = head_mask[i];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (enq[i]) begin
                fifo_addr[i][wr_ptr[i]]  <= io_in_address[i*ADDR_W +: ADDR_W];
                fifo_value[i][wr_ptr[i]] <= io_in_value[i*DATA_W +: DATA_W];
                fifo_mask[i][wr_ptr[i]]  <= io_in_byteMask[i*MASK_W +: MASK_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr         <= '0;
            io_wr_write    <= '0;
            io_wr_address  <= '0;
            io_wr_value    <= '0;
            io_wr_byteMask <= '0;
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            rr_ptr         <= rr_next;
            io_wr_write    <= wr_write_n;
            io_wr_address  <= wr_address_n;
            io_wr_value    <= wr_value_n;
            io_wr_byteMask <= wr_mask_n;
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (enq[i])   wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (grant[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                case ({enq[i], grant[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    always_comb begin
        io_pending = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            io_pending = io_pending + PEND_W'(count[i]);
        end
    end

    assign io_idle = (io_pending == '0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_regfile_write_arbiter;

    localparam int NUM_IN     = 12;
    localparam int NUM_PORTS  = 8;
    localparam int FIFO_DEPTH = 2;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 64;
    localparam int MASK_W     = DATA_W / 8;
    localparam int PEND_W     = $clog2(NUM_IN * FIFO_DEPTH + 1);

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] value;
        logic [MASK_W-1:0] mask;
    } req_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [NUM_IN-1:0]           in_valid   = '0;
    logic [NUM_IN*ADDR_W-1:0]    in_address = '0;
    logic [NUM_IN*DATA_W-1:0]    in_value   = '0;
    logic [NUM_IN*MASK_W-1:0]    in_mask    = '0;
    logic [NUM_IN-1:0]           in_ready;
    logic [NUM_PORTS-1:0]        wr_write;
    logic [NUM_PORTS*ADDR_W-1:0] wr_address;
    logic [NUM_PORTS*DATA_W-1:0] wr_value;
    logic [NUM_PORTS*MASK_W-1:0] wr_mask;
    logic [PEND_W-1:0]           pending;
    logic                        idle;

    always #5 clock = ~clock;

    regfile_write_arbiter #(
        .NUM_IN(NUM_IN), .NUM_PORTS(NUM_PORTS), .FIFO_DEPTH(FIFO_DEPTH),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(in_ready),
        .io_in_address(in_address), .io_in_value(in_value), .io_in_byteMask(in_mask),
        .io_wr_write(wr_write), .io_wr_address(wr_address),
        .io_wr_value(wr_value), .io_wr_byteMask(wr_mask),
        .io_pending(pending), .io_idle(idle)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    req_t stim_q  [NUM_IN][$];
    req_t model_q [NUM_IN][$];
    int   rp_m;
    logic [NUM_PORTS-1:0]        exp_write;
    logic [NUM_PORTS*ADDR_W-1:0] exp_addr;
    logic [NUM_PORTS*DATA_W-1:0] exp_value;
    logic [NUM_PORTS*MASK_W-1:0] exp_mask;

    int   m_used, m_next, m_ln;
    bit   m_skipped;
    bit   m_taken   [128];
    bit   m_granted [NUM_IN];
    bit   m_acc     [NUM_IN];
    req_t m_h, m_r;

    int          obs_cnt [128];
    logic [63:0] obs20 [$];
    bit          t6_en = 0;
    int          t6_first = -1;
    int          t6_last [NUM_IN];
    int          t6_cnt  [NUM_IN];
    int          t6_maxgap = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int lane, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] v, input logic [MASK_W-1:0] m);
        req_t r;
        r.addr = a; r.value = v; r.mask = m;
        stim_q[lane].push_back(r);
    endtask

    // Called right after a negedge; returns 2 time units after the following negedge.
    task automatic do_reset();
        #2 reset = 1'b1;
        for (int i = 0; i < NUM_IN; i++) stim_q[i].delete();
        @(negedge clock);
        chk("reset_write", wr_write, 0);
        chk("reset_pending", pending, 0);
        chk("reset_idle", idle, 1);
        chk("reset_ready", in_ready, 0);
        #2 reset = 1'b0;
    endtask

    // Reference model: updates at each edge, then drives the next stimulus.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_IN; i++) model_q[i].delete();
            rp_m = 0;
            exp_write = '0; exp_addr = '0; exp_value = '0; exp_mask = '0;
        end else begin
            for (int a = 0; a < 128; a++) m_taken[a] = 0;
            for (int i = 0; i < NUM_IN; i++) begin
                m_granted[i] = 0;
                m_acc[i] = in_valid[i] && (model_q[i].size() < FIFO_DEPTH);
            end
            exp_write = '0; exp_addr = '0; exp_value = '0; exp_mask = '0;
            m_used = 0; m_skipped = 0; m_next = rp_m;
            for (int j = 0; j < NUM_IN; j++) begin
                m_ln = (rp_m + j) % NUM_IN;
                if (model_q[m_ln].size() != 0) begin
                    m_h = model_q[m_ln][0];
                    if (m_used < NUM_PORTS && !m_taken[m_h.addr]) begin
                        m_taken[m_h.addr] = 1;
                        m_granted[m_ln] = 1;
                        exp_write[m_used] = 1'b1;
                        exp_addr[m_used*ADDR_W +: ADDR_W]  = m_h.addr;
                        exp_value[m_used*DATA_W +: DATA_W] = m_h.value;
                        exp_mask[m_used*MASK_W +: MASK_W]  = m_h.mask;
                        m_used++;
                    end else if (!m_skipped) begin
                        m_skipped = 1;
                        m_next = m_ln;
                    end
                end
            end
            if (!m_skipped && m_used > 0) m_next = (rp_m + 1) % NUM_IN;
            rp_m = m_next;
            for (int i = 0; i < NUM_IN; i++) begin
                if (m_granted[i]) void'(model_q[i].pop_front());
                if (m_acc[i]) begin
                    m_r.addr  = in_address[i*ADDR_W +: ADDR_W];
                    m_r.value = in_value[i*DATA_W +: DATA_W];
                    m_r.mask  = in_mask[i*MASK_W +: MASK_W];
                    model_q[i].push_back(m_r);
                    void'(stim_q[i].pop_front());
                end
            end
        end
        #1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (stim_q[i].size() != 0) begin
                in_valid[i] = 1'b1;
                in_address[i*ADDR_W +: ADDR_W] = stim_q[i][0].addr;
                in_value[i*DATA_W +: DATA_W]   = stim_q[i][0].value;
                in_mask[i*MASK_W +: MASK_W]    = stim_q[i][0].mask;
            end else begin
                in_valid[i] = 1'b0;
                in_address[i*ADDR_W +: ADDR_W] = '0;
                in_value[i*DATA_W +: DATA_W]   = '0;
                in_mask[i*MASK_W +: MASK_W]    = '0;
            end
        end
    end

    always @(negedge clock) begin : compare
        logic [NUM_IN-1:0] er;
        int  psum;
        bit  dup;
        int  a, ln;
        cyc++;
        psum = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            er[i] = !reset && (model_q[i].size() < FIFO_DEPTH);
            psum += model_q[i].size();
        end
        chk("wr_write", wr_write, exp_write);
        chk("wr_address", wr_address, exp_addr);
        chk("wr_value", wr_value, exp_value);
        chk("wr_byteMask", wr_mask, exp_mask);
        chk("in_ready", in_ready, er);
        chk("pending", pending, psum);
        chk("idle", idle, psum == 0);
        dup = 0;
        for (int k = 0; k < NUM_PORTS; k++)
            for (int m = k + 1; m < NUM_PORTS; m++)
                if (wr_write[k] && wr_write[m] &&
                    wr_address[k*ADDR_W +: ADDR_W] == wr_address[m*ADDR_W +: ADDR_W]) dup = 1;
        chk("dup_addr_same_cycle", dup, 0);
        chk("port_packing", (wr_write & (wr_write + 1'b1)) != 0, 0);
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (wr_write[k]) begin
                a = int'(wr_address[k*ADDR_W +: ADDR_W]);
                obs_cnt[a]++;
                if (a == 'h20) obs20.push_back(wr_value[k*DATA_W +: DATA_W]);
                if (t6_en && a >= 'h50 && a < 'h50 + NUM_IN) begin
                    if (t6_first < 0) t6_first = cyc;
                    if (cyc - t6_first < 30) begin
                        ln = a - 'h50;
                        if (t6_last[ln] >= 0 && cyc - t6_last[ln] > t6_maxgap)
                            t6_maxgap = cyc - t6_last[ln];
                        t6_last[ln] = cyc;
                        t6_cnt[ln]++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : directed
        logic [NUM_PORTS*ADDR_W-1:0] ea;
        logic [NUM_PORTS*DATA_W-1:0] ev;
        for (int a = 0; a < 128; a++) obs_cnt[a] = 0;
        @(negedge clock);
        do_reset();

        // 1: single write, two-cycle latency
        push(3, 7'h05, 64'hDEADBEEF_00000001, 8'hFF);
        repeat (2) @(negedge clock);
        chk("t1_pending_after_accept", pending, 1);
        @(negedge clock);
        chk("t1_write", wr_write, 8'h01);
        chk("t1_addr", wr_address[6:0], 7'h05);
        chk("t1_value", wr_value[63:0], 64'hDEADBEEF_00000001);
        chk("t1_mask", wr_mask[7:0], 8'hFF);
        @(negedge clock);
        chk("t1_idle", idle, 1);
        chk("t1_write_off", wr_write, 0);

        // 2: twelve lanes at once, eight ports
        @(negedge clock); do_reset();
        for (int i = 0; i < NUM_IN; i++) push(i, 7'(i), 64'h100 + 64'(i), 8'hFF);
        repeat (3) @(negedge clock);
        ea = '0; ev = '0;
        for (int k = 0; k < 8; k++) begin
            ea[k*ADDR_W +: ADDR_W] = 7'(k);
            ev[k*DATA_W +: DATA_W] = 64'h100 + 64'(k);
        end
        chk("t2_first_write", wr_write, 8'hFF);
        chk("t2_first_addr", wr_address, ea);
        chk("t2_first_value", wr_value, ev);
        @(negedge clock);
        ea = '0; ev = '0;
        for (int k = 0; k < 4; k++) begin
            ea[k*ADDR_W +: ADDR_W] = 7'(k + 8);
            ev[k*DATA_W +: DATA_W] = 64'h108 + 64'(k);
        end
        chk("t2_second_write", wr_write, 8'h0F);
        chk("t2_second_addr", wr_address, ea);
        chk("t2_second_value", wr_value, ev);

        // 3: same address on lanes 0 and 1, zero byte mask on lane 1
        @(negedge clock); do_reset();
        push(0, 7'h10, 64'hAAAA_0000, 8'h0F);
        push(1, 7'h10, 64'hBBBB_0000, 8'h00);
        repeat (3) @(negedge clock);
        chk("t3_lane0_write", wr_write, 8'h01);
        chk("t3_lane0_value", wr_value[63:0], 64'hAAAA_0000);
        @(negedge clock);
        chk("t3_lane1_write", wr_write, 8'h01);
        chk("t3_lane1_value", wr_value[63:0], 64'hBBBB_0000);
        chk("t3_lane1_mask", wr_mask[7:0], 8'h00);
        @(negedge clock);
        chk("t3_done", wr_write, 0);

        // 4: lane 2 blocked behind lanes 3-10 once the pointer sits at 3
        @(negedge clock); do_reset();
        for (int s = 0; s < 3; s++) push(11, 7'(8'h61 + s), 64'(s), 8'h01);
        repeat (3) @(negedge clock);
        #2;
        for (int s = 1; s <= 3; s++) push(2, 7'h20, 64'(s), 8'hFF);
        for (int i = 3; i <= 10; i++)
            for (int s = 0; s < 4; s++) push(i, 7'(8'h40 + i), 64'(i * 16 + s), 8'hF0);
        repeat (2) @(negedge clock);
        chk("t4_ready2_one_entry", in_ready[2], 1);
        @(negedge clock);
        chk("t4_ready2_full", in_ready[2], 0);
        chk("t4_saturated", wr_write, 8'hFF);
        repeat (12) @(negedge clock);
        chk("t4_lane2_count", obs20.size(), 3);
        for (int s = 0; s < 3; s++) chk("t4_lane2_order", obs20[s], 64'(s + 1));

        // 5: reset with ten entries buffered
        @(negedge clock); do_reset();
        for (int i = 0; i < 10; i++) push(i, 7'h33, 64'h5500 + 64'(i), 8'hFF);
        repeat (2) @(negedge clock);
        chk("t5_pending_10", pending, 10);
        do_reset();
        repeat (6) @(negedge clock);
        chk("t5_dropped", obs_cnt['h33], 0);
        chk("t5_pending_after", pending, 0);

        // 6: all lanes continuously valid
        @(negedge clock); do_reset();
        for (int i = 0; i < NUM_IN; i++) begin
            t6_last[i] = -1;
            t6_cnt[i]  = 0;
        end
        t6_en = 1;
        for (int i = 0; i < NUM_IN; i++)
            for (int s = 0; s < 40; s++)
                push(i, 7'(8'h50 + i), {32'(i), 32'(s)}, 8'(i));
        repeat (90) @(negedge clock);
        for (int i = 0; i < NUM_IN; i++) begin
            chk("t6_window_grants", t6_cnt[i], 20);
            chk("t6_total_writes", obs_cnt['h50 + i], 40);
        end
        chk("t6_max_gap", t6_maxgap, 2);
        chk("t6_idle_end", idle, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
